// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS-Lite controller: states, opcodes,
// datapath select codes and the decoded-instruction record.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXE = 4'd3,
    S_ALUWB = 4'd4, S_MA = 4'd5, S_MR = 4'd6, S_MWB = 4'd7,
    S_MW = 4'd8, S_BR = 4'd9, S_JMP = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // BE_sel bits: [0] byte, [1] half, [2] sign-extend
  localparam logic [2:0] BE_WORD = 3'b000;
  localparam logic [2:0] BE_LB   = 3'b101;
  localparam logic [2:0] BE_LBU  = 3'b001;
  localparam logic [2:0] BE_LH   = 3'b110;
  localparam logic [2:0] BE_LHU  = 3'b010;
  localparam logic [2:0] BE_SB   = 3'b001;
  localparam logic [2:0] BE_SH   = 3'b010;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BEQ, C_JMP, C_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic       rtype;
    logic       addi;
    logic       jal;
    logic       jr;
    logic       alusrc;
    logic [2:0] aluop;
    logic [2:0] be_sel;
    logic       extop;
  } dec_t;

  function automatic logic [2:0] be_code(input logic [5:0] op);
    case (op)
      OP_LB:   return BE_LB;
      OP_LBU:  return BE_LBU;
      OP_LH:   return BE_LH;
      OP_LHU:  return BE_LHU;
      OP_SB:   return BE_SB;
      OP_SH:   return BE_SH;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational IR decode: op/func to instruction class plus the controls
// that stay constant for the whole instruction.
module mc_decode
  import multicycle_controller_pkg::*;
#(
  parameter bit HAS_BYTE_OPS = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.cls = C_ILL;
    case (op)
      OP_RTYPE:
        case (func)
          FN_ADDU: begin dec.cls = C_ALU; dec.rtype = 1'b1; dec.aluop = ALU_ADD; end
          FN_SUBU: begin dec.cls = C_ALU; dec.rtype = 1'b1; dec.aluop = ALU_SUB; end
          FN_SLT:  begin dec.cls = C_ALU; dec.rtype = 1'b1; dec.aluop = ALU_SLT; end
          FN_JR:   begin dec.cls = C_JMP; dec.jr = 1'b1; end
          default: ;
        endcase
      OP_ORI:   begin dec.cls = C_ALU; dec.alusrc = 1'b1; dec.aluop = ALU_OR; end
      OP_LUI:   begin dec.cls = C_ALU; dec.alusrc = 1'b1; dec.aluop = ALU_LUI; dec.extop = 1'b1; end
      OP_ADDI:  begin dec.cls = C_ALU; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.addi = 1'b1; end
      OP_ADDIU: begin dec.cls = C_ALU; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; end
      OP_SLTI:  begin dec.cls = C_ALU; dec.alusrc = 1'b1; dec.aluop = ALU_SLT; end
      OP_LW:    begin dec.cls = C_LOAD;  dec.alusrc = 1'b1; dec.aluop = ALU_ADD; end
      OP_SW:    begin dec.cls = C_STORE; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; end
      OP_LB, OP_LBU, OP_LH, OP_LHU:
        if (HAS_BYTE_OPS) begin
          dec.cls = C_LOAD; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.be_sel = be_code(op);
        end
      OP_SB, OP_SH:
        if (HAS_BYTE_OPS) begin
          dec.cls = C_STORE; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.be_sel = be_code(op);
        end
      OP_BEQ:   begin dec.cls = C_BEQ; dec.aluop = ALU_SUB; end
      OP_J:     dec.cls = C_JMP;
      OP_JAL:   begin dec.cls = C_JMP; dec.jal = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-Lite control FSM with memory ready handshake and a
// per-wait-state watchdog that aborts stalled fetches and data accesses.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          HAS_BYTE_OPS   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] Regdst,
  output logic       Alusrc,
  output logic       Memwrite,
  output logic [1:0] Memtoreg,
  output logic [2:0] BE_sel,
  output logic       Regwrite,
  output logic [1:0] nPC_sel,
  output logic       Extop,
  output logic [2:0] Aluop,
  output logic       illegal_instr,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     cur, nxt;
  dec_t       dec;
  logic [7:0] wd_cnt;
  logic       waiting, ready, timeout;

  mc_decode #(.HAS_BYTE_OPS(HAS_BYTE_OPS)) u_dec (.op(op), .func(func), .dec(dec));

  // A ready arriving on the last allowed cycle still completes the access.
  always_comb begin
    waiting = (cur == S_FETCH) || (cur == S_MR) || (cur == S_MW);
    ready   = (cur == S_FETCH) ? imem_ready : dmem_ready;
    timeout = waiting && !ready && (wd_cnt == WD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_RST;
    else        cur <= nxt;
  end

  // Counter restarts on every state change and on a FETCH->FETCH timeout retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wd_cnt <= '0;
    else if (nxt != cur || timeout)  wd_cnt <= '0;
    else if (waiting)                wd_cnt <= wd_cnt + 8'd1;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (dec.cls)
          C_ALU:            nxt = S_EXE;
          C_LOAD, C_STORE:  nxt = S_MA;
          C_BEQ:            nxt = S_BR;
          C_JMP:            nxt = S_JMP;
          default:          nxt = S_FETCH;
        endcase
      S_EXE:    nxt = S_ALUWB;
      S_MA:     nxt = (dec.cls == C_LOAD) ? S_MR : S_MW;
      S_MR:     nxt = dmem_ready ? S_MWB : (timeout ? S_FETCH : S_MR);
      S_MW:     nxt = (dmem_ready || timeout) ? S_FETCH : S_MW;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0; dmem_req = 1'b0; PCWr = 1'b0; IRWr = 1'b0;
    Regdst = RD_RT; Alusrc = 1'b0; Memwrite = 1'b0; Memtoreg = M2R_ALU;
    BE_sel = BE_WORD; Regwrite = 1'b0; nPC_sel = NPC_SEQ; Extop = 1'b0;
    Aluop = ALU_NONE; illegal_instr = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin IRWr = 1'b1; PCWr = 1'b1; nPC_sel = NPC_SEQ; end
      end
      S_DECODE: illegal_instr = (dec.cls == C_ILL);
      S_EXE: begin
        Alusrc = dec.alusrc; Aluop = dec.aluop; Extop = dec.extop;
      end
      // ALU stays driven so overflow is live for the addi write suppression.
      S_ALUWB: begin
        Alusrc   = dec.alusrc; Aluop = dec.aluop; Extop = dec.extop;
        Regwrite = !(dec.addi && overflow);
        Regdst   = dec.rtype ? RD_RD : RD_RT;
      end
      S_MA: begin Alusrc = 1'b1; Aluop = ALU_ADD; end
      S_MR: begin dmem_req = 1'b1; BE_sel = dec.be_sel; end
      S_MWB: begin Regwrite = 1'b1; Memtoreg = M2R_MEM; Regdst = RD_RT; end
      S_MW: begin dmem_req = 1'b1; Memwrite = 1'b1; BE_sel = dec.be_sel; end
      S_BR: begin Aluop = ALU_SUB; nPC_sel = NPC_BR; PCWr = zero; end
      S_JMP: begin
        PCWr    = 1'b1;
        nPC_sel = dec.jr ? NPC_JR : NPC_JMP;
        if (dec.jal) begin Regwrite = 1'b1; Regdst = RD_R31; Memtoreg = M2R_PC4; end
      end
      default: ;
    endcase
  end

  assign bus_err = timeout;
  assign state   = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table sweep, directed corner
// sequences and randomized ready timing against a per-instruction trace model.
module tb_multicycle_controller;

  localparam int T = 4;

  localparam logic [3:0] K_R = 0, K_I = 1, K_ADDI = 2, K_LD = 3, K_ST = 4,
                         K_BEQ = 5, K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

  typedef struct packed {
    logic imem_req, dmem_req, PCWr, IRWr;
    logic [1:0] Regdst;
    logic Alusrc, Memwrite;
    logic [1:0] Memtoreg;
    logic [2:0] BE_sel;
    logic Regwrite;
    logic [1:0] nPC_sel;
    logic Extop;
    logic [2:0] Aluop;
    logic illegal_instr, bus_err;
    logic [3:0] state;
  } outs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] kind;
    logic       alusrc;
    logic [2:0] aluop;
    logic [2:0] be;
    logic       extop;
  } ins_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic zero = 1'b0, overflow = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;

  logic imem_req, dmem_req, PCWr, IRWr, Alusrc, Memwrite, Regwrite, Extop, illegal_instr, bus_err;
  logic [1:0] Regdst, Memtoreg, nPC_sel;
  logic [2:0] BE_sel, Aluop;
  logic [3:0] state;
  logic nb_imem_req, nb_dmem_req, nb_PCWr, nb_IRWr, nb_Alusrc, nb_Memwrite, nb_Regwrite, nb_Extop;
  logic nb_illegal_instr, nb_bus_err;
  logic [1:0] nb_Regdst, nb_Memtoreg, nb_nPC_sel;
  logic [2:0] nb_BE_sel, nb_Aluop;
  logic [3:0] nb_state;

  outs_t got, nbg;
  assign got = {imem_req, dmem_req, PCWr, IRWr, Regdst, Alusrc, Memwrite, Memtoreg, BE_sel,
                Regwrite, nPC_sel, Extop, Aluop, illegal_instr, bus_err, state};
  assign nbg = {nb_imem_req, nb_dmem_req, nb_PCWr, nb_IRWr, nb_Regdst, nb_Alusrc, nb_Memwrite,
                nb_Memtoreg, nb_BE_sel, nb_Regwrite, nb_nPC_sel, nb_Extop, nb_Aluop,
                nb_illegal_instr, nb_bus_err, nb_state};

  multicycle_controller #(.TIMEOUT_CYCLES(T), .HAS_BYTE_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .overflow(overflow),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .PCWr(PCWr), .IRWr(IRWr), .Regdst(Regdst), .Alusrc(Alusrc), .Memwrite(Memwrite),
    .Memtoreg(Memtoreg), .BE_sel(BE_sel), .Regwrite(Regwrite), .nPC_sel(nPC_sel), .Extop(Extop),
    .Aluop(Aluop), .illegal_instr(illegal_instr), .bus_err(bus_err), .state(state));

  multicycle_controller #(.TIMEOUT_CYCLES(16), .HAS_BYTE_OPS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .overflow(overflow),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(nb_imem_req),
    .dmem_req(nb_dmem_req), .PCWr(nb_PCWr), .IRWr(nb_IRWr), .Regdst(nb_Regdst),
    .Alusrc(nb_Alusrc), .Memwrite(nb_Memwrite), .Memtoreg(nb_Memtoreg), .BE_sel(nb_BE_sel),
    .Regwrite(nb_Regwrite), .nPC_sel(nb_nPC_sel), .Extop(nb_Extop), .Aluop(nb_Aluop),
    .illegal_instr(nb_illegal_instr), .bus_err(nb_bus_err), .state(nb_state));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  ins_t tbl [22];

  function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input logic [3:0] k,
                              input logic as, input logic [2:0] ao, input logic [2:0] be,
                              input logic ex);
    ins_t r;
    r.op = o; r.func = f; r.kind = k; r.alusrc = as; r.aluop = ao; r.be = be; r.extop = ex;
    return r;
  endfunction

  function automatic outs_t st(input int s);
    outs_t x = '0;
    x.state = 4'(s);
    return x;
  endfunction

  task automatic chk(input outs_t g, input outs_t e, input string tag);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) want %h (state %0d) at %0t", tag, g, g.state, e, e.state, $time);
    end
  endtask

  // Inputs are already driven; sample at the falling edge, then step one cycle.
  task automatic cyc(input outs_t e, input bit mask_req, input string tag);
    outs_t g;
    @(negedge clk);
    g = got;
    if (mask_req) begin g.imem_req = e.imem_req; g.dmem_req = e.dmem_req; end
    chk(g, e, tag);
    @(posedge clk); #1;
  endtask

  // Expected cycle-by-cycle trace of one instruction: fd/dd are the number of
  // cycles imem_ready/dmem_ready stay low before rising.
  task automatic run(input int idx, input int fd, input int dd, input logic z, input logic ov);
    ins_t  e = tbl[idx];
    outs_t x;
    int    w;
    op = e.op; func = e.func; zero = z; overflow = ov; dmem_ready = 1'b0;
    w = 0;
    while (1) begin
      x = st(1); x.imem_req = 1'b1;
      imem_ready = (fd == 0);
      if (fd == 0) begin
        x.IRWr = 1'b1; x.PCWr = 1'b1;
        cyc(x, 0, $sformatf("fetch[%0d]", idx));
        break;
      end
      if (w == T - 1) begin
        x.bus_err = 1'b1; cyc(x, 1, $sformatf("fetch_timeout[%0d]", idx)); w = 0;
      end else begin
        cyc(x, 0, $sformatf("fetch_wait[%0d]", idx)); w++;
      end
      fd--;
    end
    imem_ready = 1'b0;
    x = st(2); x.illegal_instr = (e.kind == K_ILL);
    cyc(x, 0, $sformatf("decode[%0d]", idx));
    case (e.kind)
      K_R, K_I, K_ADDI: begin
        x = st(3); x.Alusrc = e.alusrc; x.Aluop = e.aluop; x.Extop = e.extop;
        cyc(x, 0, $sformatf("exe[%0d]", idx));
        x.state = 4'd4;
        x.Regwrite = !(e.kind == K_ADDI && ov);
        x.Regdst = (e.kind == K_R) ? 2'b01 : 2'b00;
        cyc(x, 0, $sformatf("aluwb[%0d]", idx));
      end
      K_LD, K_ST: begin
        x = st(5); x.Alusrc = 1'b1; x.Aluop = 3'b011;
        cyc(x, 0, $sformatf("ma[%0d]", idx));
        w = 0;
        while (1) begin
          x = st(e.kind == K_LD ? 6 : 8); x.dmem_req = 1'b1; x.BE_sel = e.be;
          x.Memwrite = (e.kind == K_ST);
          dmem_ready = (dd == 0);
          if (dd == 0) begin cyc(x, 0, $sformatf("mem_done[%0d]", idx)); break; end
          if (w == T - 1) begin
            x.bus_err = 1'b1; cyc(x, 1, $sformatf("mem_timeout[%0d]", idx));
            dmem_ready = 1'b0;
            return;
          end
          cyc(x, 0, $sformatf("mem_wait[%0d]", idx)); w++; dd--;
        end
        dmem_ready = 1'b0;
        if (e.kind == K_LD) begin
          x = st(7); x.Regwrite = 1'b1; x.Memtoreg = 2'b01;
          cyc(x, 0, $sformatf("mwb[%0d]", idx));
        end
      end
      K_BEQ: begin
        x = st(9); x.Aluop = 3'b010; x.nPC_sel = 2'b01; x.PCWr = z;
        cyc(x, 0, $sformatf("br[%0d]", idx));
      end
      K_J, K_JAL, K_JR: begin
        x = st(10); x.PCWr = 1'b1; x.nPC_sel = (e.kind == K_JR) ? 2'b11 : 2'b10;
        if (e.kind == K_JAL) begin x.Regwrite = 1'b1; x.Regdst = 2'b10; x.Memtoreg = 2'b10; end
        cyc(x, 0, $sformatf("jmp[%0d]", idx));
      end
      default: ;
    endcase
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    outs_t x;
    tbl[0]  = mk(6'b000000, 6'b100001, K_R,    0, 3'b011, 3'b000, 0); // addu
    tbl[1]  = mk(6'b000000, 6'b100011, K_R,    0, 3'b010, 3'b000, 0); // subu
    tbl[2]  = mk(6'b000000, 6'b101010, K_R,    0, 3'b100, 3'b000, 0); // slt
    tbl[3]  = mk(6'b000000, 6'b001000, K_JR,   0, 3'b000, 3'b000, 0); // jr
    tbl[4]  = mk(6'b001101, 6'b010101, K_I,    1, 3'b001, 3'b000, 0); // ori
    tbl[5]  = mk(6'b001111, 6'b000000, K_I,    1, 3'b101, 3'b000, 1); // lui
    tbl[6]  = mk(6'b001000, 6'b000000, K_ADDI, 1, 3'b011, 3'b000, 0); // addi
    tbl[7]  = mk(6'b001001, 6'b000000, K_I,    1, 3'b011, 3'b000, 0); // addiu
    tbl[8]  = mk(6'b001010, 6'b000000, K_I,    1, 3'b100, 3'b000, 0); // slti
    tbl[9]  = mk(6'b100011, 6'b000000, K_LD,   1, 3'b011, 3'b000, 0); // lw
    tbl[10] = mk(6'b101011, 6'b000000, K_ST,   1, 3'b011, 3'b000, 0); // sw
    tbl[11] = mk(6'b100000, 6'b000000, K_LD,   1, 3'b011, 3'b101, 0); // lb
    tbl[12] = mk(6'b100100, 6'b000000, K_LD,   1, 3'b011, 3'b001, 0); // lbu
    tbl[13] = mk(6'b100001, 6'b000000, K_LD,   1, 3'b011, 3'b110, 0); // lh
    tbl[14] = mk(6'b100101, 6'b000000, K_LD,   1, 3'b011, 3'b010, 0); // lhu
    tbl[15] = mk(6'b101000, 6'b000000, K_ST,   1, 3'b011, 3'b001, 0); // sb
    tbl[16] = mk(6'b101001, 6'b000000, K_ST,   1, 3'b011, 3'b010, 0); // sh
    tbl[17] = mk(6'b000100, 6'b000000, K_BEQ,  0, 3'b010, 3'b000, 0); // beq
    tbl[18] = mk(6'b000010, 6'b000000, K_J,    0, 3'b000, 3'b000, 0); // j
    tbl[19] = mk(6'b000011, 6'b000000, K_JAL,  0, 3'b000, 3'b000, 0); // jal
    tbl[20] = mk(6'b111111, 6'b000000, K_ILL,  0, 3'b000, 3'b000, 0); // bad opcode
    tbl[21] = mk(6'b000000, 6'b000000, K_ILL,  0, 3'b000, 3'b000, 0); // unsupported func

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(got, '0, "reset_outputs");
    chk(nbg, '0, "reset_outputs_nb");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) run(i, 0, 0, 1'b0, 1'b0);

    run(11, 0, 3, 1'b0, 1'b0);   // lb, dmem_ready 3 cycles late
    run(17, 0, 0, 1'b1, 1'b0);   // beq taken
    run(17, 0, 0, 1'b0, 1'b0);   // beq not taken
    run(6, 0, 0, 1'b0, 1'b1);    // addi overflow suppresses write
    run(7, 0, 0, 1'b0, 1'b1);    // addiu ignores overflow
    run(19, 0, 0, 1'b0, 1'b0);   // jal
    run(0, 5, 0, 1'b0, 1'b0);    // fetch timeout then retry
    run(9, 0, 4, 1'b0, 1'b0);    // load timeout
    run(10, 0, 3, 1'b0, 1'b0);   // store ready on the last allowed cycle
    run(16, 0, 4, 1'b0, 1'b0);   // store timeout

    for (int n = 0; n < 150; n++) begin
      int idx, fd, dd;
      idx = $urandom_range(0, 21);
      fd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 0;
      dd  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1);
      run(idx, fd, dd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // sb on the no-byte-ops build traps; the full build proceeds into MW.
    pulse_reset();
    op = 6'b101000; func = 6'b000000; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    x = st(1); x.imem_req = 1'b1; x.IRWr = 1'b1; x.PCWr = 1'b1;
    chk(nbg, x, "nb_sb_fetch");
    chk(got, x, "sb_fetch");
    @(posedge clk); #1; imem_ready = 1'b0;
    @(negedge clk);
    x = st(2); x.illegal_instr = 1'b1; chk(nbg, x, "nb_sb_illegal");
    chk(got, st(2), "sb_decode_legal");
    @(posedge clk); #1;
    @(negedge clk);
    x = st(1); x.imem_req = 1'b1; chk(nbg, x, "nb_sb_back_to_fetch");
    x = st(5); x.Alusrc = 1'b1; x.Aluop = 3'b011; chk(got, x, "sb_ma");
    @(posedge clk); #1;
    @(negedge clk);
    x = st(8); x.dmem_req = 1'b1; x.Memwrite = 1'b1; x.BE_sel = 3'b001;
    chk(got, x, "sb_mw_wait");
    #2 rst_n = 1'b0;
    #1;
    chk(got, '0, "async_reset_in_mw");
    chk(nbg, '0, "async_reset_nb");
    @(posedge clk); #1;
    chk(got, '0, "reset_held_in_mw");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 0, 0, 1'b0, 1'b0);

    imem_ready = 1'b0;
    x = st(1); x.imem_req = 1'b1;
    cyc(x, 0, "final_fetch_wait");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS-Lite decoder: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Adds a ready handshake toward instruction and data memory, a watchdog timeout, illegal-opcode trapping, addi overflow suppression and a compile-time switch for byte/half ops.
- Sits between the IR fields (op, func) and the multi-cycle datapath: PC, IR, register file, ALU, data memory and byte-enable unit.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for a memory ready before flagging bus_err; legal range 1..255.
- HAS_BYTE_OPS, 1: 1 decodes lb/lbu/lh/lhu/sb/sh; 0 treats them as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- imem_ready  in  1  instruction memory has valid data / accepted request
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- Regdst  out  2  00 rt, 01 rd, 10 r31
- Alusrc  out  1  1 = immediate operand
- Memwrite  out  1  data memory write
- Memtoreg  out  2  00 ALU, 01 memory, 10 PC+4
- BE_sel  out  3  [0] byte, [1] half, [2] sign-extend load
- Regwrite  out  1  register file write enable
- nPC_sel  out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
- Extop  out  1  1 only for lui
- Aluop  out  3  001 OR, 010 SUB, 011 ADD, 100 SLT, 101 LUI
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction
- bus_err  out  1  one-cycle pulse on a memory timeout
- state  out  4  current state, for debug

Behaviour:
- States and encoding: RST=0, FETCH=1, DECODE=2, EXE=3, ALUWB=4, MA=5, MR=6, MWB=7, MW=8, BR=9, JMP=10. Unused codes go to FETCH.
- While rst_n is low: state=RST and every output is 0. The first rising edge after release goes RST→FETCH.
- FETCH: imem_req=1. On imem_ready, assert IRWr=1 and PCWr=1 with nPC_sel=00 in the same cycle, then go to DECODE.
- DECODE:
  - addu/subu/slt/ori/lui/addi/addiu/slti → EXE.
  - Loads and stores → MA.
  - beq → BR.
  - j/jal/jr → JMP.
  - Anything else: illegal_instr=1 for one cycle, then FETCH.
- EXE: Alusrc and Aluop drive the ALU from the decoded instruction, then go to ALUWB.
- ALUWB: Regwrite=1 with Regdst=01 for R-type, 00 otherwise. For addi with overflow=1, force Regwrite=0. Then go to FETCH.
- MA: Alusrc=1, Aluop=011 (address calculation). Loads go to MR, stores go to MW.
- MR: dmem_req=1 and BE_sel valid. On dmem_ready go to MWB.
- MWB: Regwrite=1, Memtoreg=01, Regdst=00, then FETCH.
- MW: dmem_req=1, Memwrite=1, BE_sel valid. On dmem_ready go to FETCH.
- BR: Aluop=010 and nPC_sel=01. PCWr=zero. Then FETCH.
- JMP: PCWr=1 with nPC_sel=10 for j/jal and 11 for jr.
  - jal also asserts Regwrite=1, Regdst=10, Memtoreg=10, capturing PC+4 already held in PC.
  - Then FETCH.
- BE_sel values:
  - lb 101, lbu 001, lh 110, lhu 010, sb 001, sh 010.
  - Word accesses and all other cases: 000.
- Outputs not named for a state are 0 in that state.
- Watchdog:
  - An 8-bit counter clears on entry to FETCH, MR or MW and increments each cycle while that state waits for ready.
  - When the counter reaches TIMEOUT_CYCLES-1 with ready still low: bus_err=1 for one cycle, drop the request, go to FETCH.
  - No PC, IR or register writes occur on a timeout.
- Ready arriving in the same cycle as the timeout: ready wins, and bus_err stays 0.
- Ready held high continuously: FETCH lasts exactly one cycle.
- Nominal latencies with ready=1 immediately:
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j/jal/jr: 3 cycles.
- Reset asserted mid-instruction aborts it immediately with no completion writes.

Decomposition:
- Shared package:
  - State encodings.
  - Opcode and func constants.
  - Aluop, nPC_sel, Memtoreg and Regdst encodings.
  - BE_sel codes.
- Sub-module mc_decode: combinational op/func → instruction class and static controls (Alusrc, Aluop, BE_sel, Extop, illegal), honouring HAS_BYTE_OPS.
- FSM and watchdog live in multicycle_controller.

Test Plan:
- addu (op=000000, func=100001), ready=1 throughout → states 1,2,3,4; in ALUWB Regwrite=1, Regdst=01, Aluop=011; next state FETCH.
- lb (op=100000) with dmem_ready arriving 3 cycles late → MR held 3 extra cycles; in MWB Regwrite=1, Memtoreg=01; BE_sel=101 during MR.
- beq run twice, with zero=1 then zero=0 → PCWr=1 with nPC_sel=01 on the first; PCWr=0 on the second; both return to FETCH.
- addi with overflow=1 in ALUWB → Regwrite=0. jal → Regwrite=1, Regdst=10, Memtoreg=10, nPC_sel=10.
- TIMEOUT_CYCLES=4 with imem_ready held low → bus_err pulses on the 4th FETCH cycle, then FETCH re-entered; no IRWr or PCWr observed.
- HAS_BYTE_OPS=0 with sb (op=101000) → illegal_instr pulse in DECODE, then FETCH. Separately, rst_n dropped during MW → all outputs 0 asynchronously and state=0.
